// File: rtl/fir_mac.sv
// Sequential FIR multiply-accumulate: snapshots N tap words on a strobe, then
// accumulates one tap*coefficient product per cycle. Option: FIR_MAC_SATURATE_EN.
module fir_mac #(
  parameter int N     = 20,
  parameter int L     = 10,
  parameter int CW    = 10,
  parameter int SHIFT = 9
) (
  input  logic                              clk_clk,
  input  logic                              reset_n,
  input  logic                              sample_strobe,
  input  logic [N*(2*L+2)-1:0]              taps_flat,
  input  logic                              coef_we,
  input  logic [((N>1)?$clog2(N):1)-1:0]    coef_addr,
  input  logic [CW-1:0]                     coef_data,
  output logic [2*L+1:0]                    fir_out,
  output logic                              fir_valid,
  output logic                              busy,
  output logic                              overrun,
  output logic                              coef_err,
  output logic [1:0]                        fsm_state
);

  localparam int TW   = 2*L+2;
  localparam int AW   = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = TW + CW + AW;
  localparam int OW   = TW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(N-1);
  localparam logic [AW:0]   N_EXT    = (AW+1)'(N);

  logic [1:0]             state;
  logic [TW-1:0]          tap_q  [N];
  logic [CW-1:0]          coef_q [N];
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          idx;

  logic [TW-1:0]          tap_sel;
  logic [CW-1:0]          coef_sel;
  logic signed [ACCW-1:0] tap_ext;
  logic signed [ACCW-1:0] coef_ext;
  logic signed [ACCW-1:0] prod;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW-1:0] shifted;
  logic [OW-1:0]          out_next;
  logic                   coef_ok;

  assign busy      = (state == S_ACC);
  assign fsm_state = state;
  assign coef_ok   = coef_we && (state != S_ACC) && ({1'b0, coef_addr} < N_EXT);

  // Operands are sign-extended to the full accumulator width so the product
  // and running sum can never overflow within one filter pass.
  always_comb begin
    tap_sel  = tap_q[idx];
    coef_sel = coef_q[idx];
    tap_ext  = {{(ACCW-TW){tap_sel[TW-1]}}, tap_sel};
    coef_ext = {{(ACCW-CW){coef_sel[CW-1]}}, coef_sel};
    prod     = tap_ext * coef_ext;
    acc_next = acc + prod;
    shifted  = acc_next >>> SHIFT;
`ifdef FIR_MAC_SATURATE_EN
    if ((&shifted[ACCW-1:OW-1]) || !(|shifted[ACCW-1:OW-1])) begin
      out_next = shifted[OW-1:0];
    end else if (shifted[ACCW-1]) begin
      out_next = {1'b1, {(OW-1){1'b0}}};
    end else begin
      out_next = {1'b0, {(OW-1){1'b1}}};
    end
`else
    out_next = acc_next[SHIFT+OW-1:SHIFT];
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      fir_out   <= '0;
      fir_valid <= 1'b0;
      overrun   <= 1'b0;
      coef_err  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      fir_valid <= 1'b0;
      coef_err  <= coef_we && !coef_ok;
      if (coef_ok) begin
        coef_q[coef_addr] <= coef_data;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (sample_strobe) begin
            for (int k = 0; k < N; k++) begin
              tap_q[k] <= taps_flat[k*TW +: TW];
            end
            acc   <= '0;
            idx   <= '0;
            state <= S_ACC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACC: begin
          acc <= acc_next;
          if (sample_strobe) begin
            overrun <= 1'b1;
          end
          // Result is registered on the last product so it lines up with DONE.
          if (idx == LAST_IDX) begin
            fir_out   <= out_next;
            fir_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac.sv
// Bench for fir_mac: two instances (SHIFT=0 and SHIFT=9) share stimulus and are
// checked against a cycle-count reference model through an expected-result queue.
module tb_fir_mac;

  localparam int N  = 20;
  localparam int L  = 10;
  localparam int CW = 10;
  localparam int TW = 2*L+2;
  localparam int AW = 5;

  logic              clk_clk;
  logic              reset_n;
  logic              sample_strobe;
  logic [N*TW-1:0]   taps_flat;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [CW-1:0]     coef_data;

  logic [TW-1:0]     fir_out0, fir_out9;
  logic              fir_valid0, fir_valid9;
  logic              busy0, busy9;
  logic              overrun0, overrun9;
  logic              coef_err0, coef_err9;
  logic [1:0]        fsm_state0, fsm_state9;

  fir_mac #(.N(N), .L(L), .CW(CW), .SHIFT(0)) dut0 (
    .clk_clk(clk_clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .taps_flat(taps_flat), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .fir_out(fir_out0), .fir_valid(fir_valid0),
    .busy(busy0), .overrun(overrun0), .coef_err(coef_err0),
    .fsm_state(fsm_state0)
  );

  fir_mac #(.N(N), .L(L), .CW(CW), .SHIFT(9)) dut9 (
    .clk_clk(clk_clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .taps_flat(taps_flat), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .fir_out(fir_out9), .fir_valid(fir_valid9),
    .busy(busy9), .overrun(overrun9), .coef_err(coef_err9),
    .fsm_state(fsm_state9)
  );

  // clock / reset
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // reference model state (written only by the driver process)
  logic signed [63:0] exp_q[$];
  int                 coef_m [N];
  int                 acc_left;
  logic               exp_busy, exp_overrun, exp_err, exp_valid, rst_seen;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] to_out(input logic signed [63:0] s, input int sh);
    logic signed [63:0] v;
    v = s >>> sh;
`ifdef FIR_MAC_SATURATE_EN
    if (v > 64'sd2097151) v = 64'sd2097151;
    else if (v < -64'sd2097152) v = -64'sd2097152;
`endif
    return v[TW-1:0];
  endfunction

  // One clock of stimulus; the model is advanced right after the edge.
  task automatic step(input logic strb, input logic we, input logic [AW-1:0] addr,
                      input logic [CW-1:0] data, input logic rst_active);
    logic signed [63:0] sum;
    sample_strobe = strb;
    coef_we       = we;
    coef_addr     = addr;
    coef_data     = data;
    reset_n       = !rst_active;
    @(posedge clk_clk);
    if (rst_active) begin
      acc_left    = 0;
      for (int k = 0; k < N; k++) coef_m[k] = 0;
      exp_overrun = 1'b0;
      exp_err     = 1'b0;
      exp_valid   = 1'b0;
      exp_q.delete();
      rst_seen    = 1'b1;
    end else begin
      rst_seen  = 1'b0;
      exp_err   = we && (acc_left > 0 || int'(addr) >= N);
      exp_valid = 1'b0;
      if (we && acc_left == 0 && int'(addr) < N) coef_m[addr] = int'($signed(data));
      if (strb && acc_left == 0) begin
        sum = 0;
        for (int k = 0; k < N; k++)
          sum += 64'($signed(taps_flat[k*TW +: TW])) * 64'(coef_m[k]);
        exp_q.push_back(sum);
        acc_left = N;
      end else begin
        if (strb) exp_overrun = 1'b1;
        if (acc_left > 0) begin
          acc_left--;
          if (acc_left == 0) exp_valid = 1'b1;
        end
      end
    end
    exp_busy = (acc_left > 0);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic set_taps(input logic [TW-1:0] v);
    for (int k = 0; k < N; k++) taps_flat[k*TW +: TW] = v;
  endtask

  task automatic write_all(input logic [CW-1:0] v);
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, AW'(k), v, 1'b0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [TW-1:0]      hold0, hold9;
    logic signed [63:0] s;
    hold0 = '0;
    hold9 = '0;
    forever begin
      @(negedge clk_clk);
      if (rst_seen) begin
        hold0 = '0;
        hold9 = '0;
      end
      check("busy0", 64'(busy0), 64'(exp_busy));
      check("busy9", 64'(busy9), 64'(exp_busy));
      check("overrun", 64'(overrun0), 64'(exp_overrun));
      check("overrun9", 64'(overrun9), 64'(exp_overrun));
      check("coef_err", 64'(coef_err0), 64'(exp_err));
      check("fir_valid0", 64'(fir_valid0), 64'(exp_valid));
      check("fir_valid9", 64'(fir_valid9), 64'(exp_valid));
      if (fir_valid0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(1), 64'(0));
        end else begin
          s     = exp_q.pop_front();
          hold0 = to_out(s, 0);
          hold9 = to_out(s, 9);
        end
      end
      check("fir_out_shift0", 64'(fir_out0), 64'(hold0));
      check("fir_out_shift9", 64'(fir_out9), 64'(hold9));
    end
  end

  // driver
  initial begin
    sample_strobe = 1'b0;
    coef_we       = 1'b0;
    coef_addr     = '0;
    coef_data     = '0;
    reset_n       = 1'b0;
    taps_flat     = '0;
    rst_seen      = 1'b1;
    exp_busy      = 1'b0;
    exp_overrun   = 1'b0;
    exp_err       = 1'b0;
    exp_valid     = 1'b0;
    acc_left      = 0;
    for (int k = 0; k < N; k++) coef_m[k] = 0;

    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
    idle(2);

    // all coefficients 1, all taps 3 -> 60
    write_all(10'd1);
    set_taps(22'd3);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    set_taps(22'd7);
    idle(24);

    // single nonzero coefficient -2 on tap 5 = 100 -> -200
    write_all(10'd0);
    step(1'b0, 1'b1, 5'd5, 10'h3FE, 1'b0);
    set_taps(22'd0);
    taps_flat[5*TW +: TW] = 22'd100;
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(24);

    // maximum positive taps and coefficients (saturates or wraps)
    write_all(10'd511);
    set_taps(22'h1FFFFF);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(24);

    // strobe at T and T+5 (overrun), then strobe in the DONE cycle
    set_taps(22'h3FFFF0);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(15);
    set_taps(22'd12345);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(24);

    // coefficient write during ACC, out-of-range write, reset during ACC
    step(1'b0, 1'b1, 5'd25, 10'd3, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 5'd2, 10'h155, 1'b0);
    idle(6);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    idle(25);

    // randomized traffic with changing taps
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) taps_flat[k*TW +: TW] = TW'($urandom);
      step($urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0,
           AW'($urandom_range(0, 31)),
           CW'($urandom),
           $urandom_range(0, 399) == 0);
    end
    idle(25);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
